// File: rtl/fan_pkg.sv
// Fan controller shared definitions: control/status word field positions,
// the decoded control struct and the PWM level function.
// Optional build macro: FAN_TACH_DEBOUNCE_EN (tach glitch filter).
package fan_pkg;

  // Control word fields
  localparam int FORCE_FULL_BIT = 0;
  localparam int PWM_EN_BIT     = 1;
  localparam int DUTY_LSB       = 8;
  localparam int DUTY_MSB       = 15;

  // Status word fields
  localparam int ST_CNT_LSB   = 0;
  localparam int ST_CNT_MSB   = 15;
  localparam int ST_STALL_BIT = 16;
  localparam int ST_WDONE_BIT = 17;
  localparam int ST_DUTY_LSB  = 24;
  localparam int ST_DUTY_MSB  = 31;

  // Value the fan-control PIO presents out of reset (force_full)
  localparam logic [31:0] CTRL_RESET_WORD = 32'h1;

  typedef struct packed {
    logic       force_full;
    logic       pwm_en;
    logic [7:0] duty;
  } fan_ctrl_t;

  function automatic fan_ctrl_t decode_ctrl(input logic [31:0] w);
    fan_ctrl_t c;
    c.force_full = w[FORCE_FULL_BIT];
    c.pwm_en     = w[PWM_EN_BIT];
    c.duty       = w[DUTY_MSB:DUTY_LSB];
    return c;
  endfunction

  // Output level for a given applied setting at a given position in the period
  function automatic logic pwm_level(input fan_ctrl_t c, input logic [7:0] cnt);
    logic lvl;
    if (c.force_full)   lvl = 1'b1;
    else if (!c.pwm_en) lvl = 1'b0;
    else                lvl = (cnt < c.duty);
    return lvl;
  endfunction

endpackage

// File: rtl/fan_tach_counter.sv
// Tachometer measurement: 2-flop synchronizer, optional glitch filter
// (FAN_TACH_DEBOUNCE_EN), rising-edge detect, free-running measurement
// window, saturating edge counter and per-window latch with a done toggle.
module fan_tach_counter #(
  parameter int WINDOW_CYCLES   = 50000000,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        tach_i,
  output logic        win_wrap_o,
  output logic [15:0] win_cnt_o,
  output logic [15:0] cnt_lat_o,
  output logic        wdone_o
);

  localparam int WW = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
  localparam logic [WW-1:0] WIN_LAST = WW'(WINDOW_CYCLES - 1);

  logic          s1_q, s2_q;
  logic          lvl;
  logic          prev_q;
  logic          rise;
  logic [WW-1:0] win_q, win_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [15:0]   lat_q, lat_d;
  logic          wdone_q, wdone_d;

  // Bring the asynchronous tach signal into the clk domain
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= tach_i;
      s2_q <= s1_q;
    end
  end

`ifdef FAN_TACH_DEBOUNCE_EN
  localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);

  logic           filt_q, filt_d;
  logic [DBW-1:0] db_q, db_d;

  // Filtered level follows the input only after it has held for DEBOUNCE_CYCLES
  always_comb begin
    filt_d = filt_q;
    db_d   = '0;
    if (s2_q != filt_q) begin
      if (db_q == DB_LAST) filt_d = s2_q;
      else                 db_d   = db_q + 1'b1;
    end
  end

  // Glitch filter state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      filt_q <= 1'b0;
      db_q   <= '0;
    end else begin
      filt_q <= filt_d;
      db_q   <= db_d;
    end
  end

  assign lvl = filt_q;
`else
  logic db_unused;
  assign db_unused = (DEBOUNCE_CYCLES != 0);
  assign lvl       = s2_q;
`endif

  assign rise = lvl & ~prev_q;

  // Window timing, saturating count and end-of-window latch
  always_comb begin
    win_wrap_o = (win_q == WIN_LAST);
    win_d      = win_wrap_o ? '0 : win_q + 1'b1;
    lat_d      = lat_q;
    wdone_d    = wdone_q;
    cnt_d      = cnt_q;
    if (win_wrap_o) begin
      // An edge coinciding with the wrap belongs to the new window
      lat_d   = cnt_q;
      wdone_d = ~wdone_q;
      cnt_d   = {15'd0, rise};
    end else if (rise && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // Edge-detect history, window and count registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q  <= 1'b0;
      win_q   <= '0;
      cnt_q   <= '0;
      lat_q   <= '0;
      wdone_q <= 1'b0;
    end else begin
      prev_q  <= lvl;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
      lat_q   <= lat_d;
      wdone_q <= wdone_d;
    end
  end

  assign win_cnt_o = cnt_q;
  assign cnt_lat_o = lat_q;
  assign wdone_o   = wdone_q;

endmodule

// File: rtl/fan_pwm_tach.sv
// Fan PWM generator and tach monitor between the fan-control PIO and the
// fan connector. Settings are applied only at PWM period boundaries so the
// output never produces a runt pulse; out of reset the fan runs at full speed.
// Optional build macro: FAN_TACH_DEBOUNCE_EN (tach glitch filter).
module fan_pwm_tach
  import fan_pkg::*;
#(
  parameter int PWM_DIV         = 8,
  parameter int WINDOW_CYCLES   = 50000000,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] ctrl_word,
  input  logic        tach_in,
  output logic        pwm_out,
  output logic [31:0] status_word,
  output logic        stall_pulse
);

  localparam int PW = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PWM_DIV - 1);
  // Applied state out of reset: force_full with zero duty
  localparam fan_ctrl_t APP_RESET = '{force_full: 1'b1, pwm_en: 1'b0, duty: 8'd0};

  logic [PW-1:0] presc_q, presc_d;
  logic          tick;
  logic [7:0]    pwm_cnt_q, pwm_cnt_d;
  fan_ctrl_t     app_q, app_d;
  logic          pwm_q, pwm_d;
  logic          fan_on;
  logic          stall_q, stall_d;
  logic          spulse_q, spulse_d;

  logic          win_wrap;
  logic [15:0]   win_cnt;
  logic [15:0]   cnt_lat;
  logic          wdone;

  logic          ctrl_unused;
  assign ctrl_unused = ^{ctrl_word[31:16], ctrl_word[7:2]};

  fan_tach_counter #(
    .WINDOW_CYCLES  (WINDOW_CYCLES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_tach (
    .clk       (clk),
    .reset_n   (reset_n),
    .tach_i    (tach_in),
    .win_wrap_o(win_wrap),
    .win_cnt_o (win_cnt),
    .cnt_lat_o (cnt_lat),
    .wdone_o   (wdone)
  );

  // Prescaler, period counter, boundary sampling, PWM level and stall decision
  always_comb begin
    tick      = (presc_q == PRESC_LAST);
    presc_d   = tick ? '0 : presc_q + 1'b1;
    pwm_cnt_d = tick ? pwm_cnt_q + 8'd1 : pwm_cnt_q;
    app_d     = (tick && (pwm_cnt_q == 8'hFF)) ? decode_ctrl(ctrl_word) : app_q;
    // Level computed from next-state values so the output lines up with pwm_cnt
    pwm_d     = pwm_level(app_d, pwm_cnt_d);
    fan_on    = app_q.force_full | (app_q.pwm_en & (app_q.duty != 8'd0));
    stall_d   = stall_q;
    spulse_d  = 1'b0;
    if (win_wrap) begin
      stall_d  = fan_on & (win_cnt == 16'd0);
      spulse_d = stall_d & ~stall_q;
    end
  end

  // PWM and stall state registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_q   <= '0;
      pwm_cnt_q <= '0;
      app_q     <= APP_RESET;
      pwm_q     <= 1'b1;
      stall_q   <= 1'b0;
      spulse_q  <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      pwm_cnt_q <= pwm_cnt_d;
      app_q     <= app_d;
      pwm_q     <= pwm_d;
      stall_q   <= stall_d;
      spulse_q  <= spulse_d;
    end
  end

  // Status word assembly from registered fields
  always_comb begin
    status_word                            = '0;
    status_word[ST_CNT_MSB:ST_CNT_LSB]     = cnt_lat;
    status_word[ST_STALL_BIT]              = stall_q;
    status_word[ST_WDONE_BIT]              = wdone;
    status_word[ST_DUTY_MSB:ST_DUTY_LSB]   = app_q.duty;
  end

  assign pwm_out     = pwm_q;
  assign stall_pulse = spulse_q;

endmodule
